// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store sequencer: access-size codes, FSM
// state encoding and the byte-lane mask helper.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Little-endian byte enables for an access of the given size at byte offset lo.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << lo;
            SIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store sequencer (slave).
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: fault detection on the incoming request, load
// extraction with sign/zero extension, and sub-word store merge.
// Optional macro MEM_ACCESS_RANGE_CHECK_EN adds an address range fault.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 32
) (
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [1:0]        chk_size,
    input  logic [1:0]        lane_addr,
    input  logic [1:0]        lane_size,
    input  logic              lane_signed,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rword,
    output logic [31:0]       load_data,
    output logic [31:0]       merge_word,
    output logic              fault
);

    logic        align_fault;
    logic        range_fault;
    logic [31:0] shifted;
    logic [31:0] wrep;
    logic [3:0]  byte_en;

    always_comb begin
        align_fault = 1'b0;
        case (chk_size)
            SIZE_BYTE: align_fault = 1'b0;
            SIZE_HALF: align_fault = chk_addr[0];
            SIZE_WORD: align_fault = (chk_addr[1:0] != 2'b00);
            default:   align_fault = 1'b1;
        endcase
    end

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    assign range_fault = (chk_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS));
`else
    logic unused_range;
    assign unused_range = (^chk_addr[ADDR_W-1:2]) ^ (MEM_WORDS > 0);
    assign range_fault  = 1'b0;
`endif

    assign fault = align_fault | range_fault;

    // Bring the addressed lane down to bit 0 before extending.
    assign shifted = rword >> {lane_addr, 3'b000};

    always_comb begin
        load_data = rword;
        case (lane_size)
            SIZE_BYTE: load_data = {{24{lane_signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data = {{16{lane_signed & shifted[15]}}, shifted[15:0]};
            default:   load_data = rword;
        endcase
    end

    // Replicate the store value across all lanes; byte enables pick which land.
    always_comb begin
        wrep = wdata;
        case (lane_size)
            SIZE_BYTE: wrep = {4{wdata[7:0]}};
            SIZE_HALF: wrep = {2{wdata[15:0]}};
            default:   wrep = wdata;
        endcase
    end

    assign byte_en = lane_mask(lane_size, lane_addr);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merge_word[8*gi +: 8] = byte_en[gi] ? wrep[8*gi +: 8] : rword[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: turns byte/half/word requests into word accesses on a
// combinational-read memory port, with read-modify-write for sub-word stores.
// Optional macro MEM_ACCESS_RANGE_CHECK_EN faults requests beyond MEM_WORDS.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    mem_access_unit_if.slave   exe,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [ADDR_W-1:0]  Address,
    output logic [31:0]        WriteData,
    input  logic [31:0]        ReadData
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        size_reg;
    logic              write_reg;
    logic              signed_reg;
    logic [31:0]       wdata_reg;
    logic              fault_reg;
    logic [31:0]       word_reg;

    logic              accept;
    logic              fault_in;
    logic [31:0]       load_data;
    logic [31:0]       merge_word;

    assign accept = (state_reg == IDLE) && exe.req_valid;

    mem_lane_align #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_align (
        .chk_addr    (exe.req_addr),
        .chk_size    (exe.req_size),
        .lane_addr   (addr_reg[1:0]),
        .lane_size   (size_reg),
        .lane_signed (signed_reg),
        .wdata       (wdata_reg),
        .rword       (word_reg),
        .load_data   (load_data),
        .merge_word  (merge_word),
        .fault       (fault_in)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_reg   <= '0;
            size_reg   <= 2'b00;
            write_reg  <= 1'b0;
            signed_reg <= 1'b0;
            wdata_reg  <= '0;
            fault_reg  <= 1'b0;
            word_reg   <= '0;
        end else begin
            if (accept) begin
                addr_reg   <= exe.req_addr;
                size_reg   <= exe.req_size;
                write_reg  <= exe.req_write;
                signed_reg <= exe.req_signed;
                wdata_reg  <= exe.req_wdata;
                fault_reg  <= fault_in;
            end
            if (state_reg == READ) begin
                word_reg <= ReadData;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (exe.req_valid) begin
                    if (fault_in)
                        state_next = RESP;
                    else if (exe.req_write && exe.req_size == SIZE_WORD)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = write_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        exe.req_ready  = 1'b0;
        exe.resp_valid = 1'b0;
        exe.resp_fault = 1'b0;
        exe.resp_rdata = '0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        Address        = '0;
        WriteData      = '0;
        case (state_reg)
            IDLE: exe.req_ready = 1'b1;
            READ: begin
                MemRead = 1'b1;
                Address = {addr_reg[ADDR_W-1:2], 2'b00};
            end
            WRITE: begin
                MemWrite  = 1'b1;
                Address   = {addr_reg[ADDR_W-1:2], 2'b00};
                WriteData = (size_reg == SIZE_WORD) ? wdata_reg : merge_word;
            end
            RESP: begin
                exe.resp_valid = 1'b1;
                exe.resp_fault = fault_reg;
                // Stores and faults return zero data.
                exe.resp_rdata = (!write_reg && !fault_reg) ? load_data : 32'h0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store sequencer that drives the word-addressed data memory port: MemRead, MemWrite, Address, WriteData, ReadData.
- The memory port reads combinationally (ReadData is high-Z when MemRead=0) and writes on the clock edge.
- The unit turns byte, halfword and word loads/stores from the execute stage into word accesses: load lane extraction with sign/zero extension, and read-modify-write for sub-word stores.
- Alignment faults are reported; a faulting request never touches memory.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; used by the optional range check.
- ADDR_W, 32, width of byte addresses on both sides.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  execute stage presents a request.
- req_ready  output  1  unit is idle and accepts a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; the sub-word value sits in the low bits.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load result; 0 for stores and faults.
- resp_fault  output  1  valid with resp_valid: misaligned, reserved size or out-of-range request.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable, sampled by memory on the clock edge.
- Address  output  ADDR_W  byte address, low 2 bits forced to 00.
- WriteData  output  32  full word to write.
- ReadData  input  32  memory read word; valid only while MemRead=1.

Behaviour:
- Reset values:
  - state = IDLE, req_ready = 1.
  - resp_valid, resp_fault, MemRead, MemWrite = 0.
  - Address, WriteData, resp_rdata = 0.
  - All latched request fields = 0.
- Request acceptance:
  - A request is accepted on a clock edge where state = IDLE and req_valid = 1.
  - req_addr, req_size, req_write, req_signed and req_wdata are latched at that edge.
  - req_ready = 1 only in IDLE, so there is no overlap.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE transitions on accept:
  - Fault → RESP.
  - Load → READ.
  - Word store → WRITE.
  - Byte or halfword store → READ.
- READ:
  - MemRead = 1, Address = {addr[31:2], 2'b00}.
  - ReadData is captured into a word register at the edge.
  - Load → RESP; sub-word store → WRITE.
- WRITE:
  - MemWrite = 1.
  - WriteData = req_wdata for a word store, otherwise the captured word with the target lane(s) replaced.
  - Next state → RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - A new request may be accepted in the cycle following RESP.
- Latency, measured from the accept edge to the cycle in which resp_valid is high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Fault: 1 cycle.
- Lanes are little-endian:
  - Byte lane = addr[1:0], at bits [8*addr[1:0] +: 8].
  - Halfword lane = addr[1], at bits [16*addr[1] +: 16].
- Fault conditions:
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] != 00.
  - size = 11.
  - On a fault: MemRead and MemWrite stay 0, resp_fault = 1, resp_rdata = 0.
- MemRead and MemWrite are never high in the same cycle. Both are 0 in IDLE and RESP.
- Reset asserted in any state:
  - Next state = IDLE.
  - A pending write is dropped: MemWrite is 0 in the cycle after the reset edge.
  - No resp_valid pulse is generated for the aborted request.
- req_valid while not in IDLE is ignored; the requester holds it until req_ready.

Optional Feature:
- Macro: MEM_ACCESS_RANGE_CHECK_EN.
- With the macro defined:
  - A request with addr[31:2] >= MEM_WORDS is a fault, handled exactly like a misaligned request (no memory access, 1-cycle fault response).
- Without the macro:
  - No range check; the address is passed through and the memory wraps or ignores it.

Decomposition:
- Package mem_access_pkg holds:
  - Size constants SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - The FSM state encoding IDLE, READ, WRITE, RESP.
- One combinational sub-module, mem_lane_align, does:
  - Load extraction and sign/zero extension.
  - Store lane merge.
  - Fault detection.
- The top-level module holds the FSM, the request latches and the captured word.

Test Plan:
- Memory word 1 = 0x8899AABB; lw at addr 0x4 → resp_valid 2 cycles after accept, rdata 0x8899AABB, fault 0.
- Same word; lb signed at addr 0x7 → rdata 0xFFFFFF88. lbu at addr 0x5 → 0x000000AA. lhu at addr 0x6 → 0x00008899.
- Memory word 2 = 0x11223344; sb data 0xEE at addr 0x9 → READ then WRITE cycle with WriteData 0x1122EE44, resp 3 cycles after accept. Word 2 = 0x1122EE44 afterwards; sh 0xBEEF at addr 0xA → word 2 = 0xBEEFEE44.
- lw at addr 0x6 and sh at addr 0x3 → resp_fault = 1 one cycle after accept, MemRead and MemWrite stay 0 throughout, memory unchanged.
- sb accepted, reset asserted during the READ state → no MemWrite pulse, no resp_valid, req_ready = 1 in the cycle after the reset edge, target word unchanged.
- With MEM_ACCESS_RANGE_CHECK_EN defined: lw at addr 0x100 (word 64) → fault. Without the macro: no fault, MemRead asserted with Address 0x100.
